// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : Parametrised UART receiver (5..9 data bits, none/odd/even
//             parity, 1 or 2 stop bits) with a double-flop synchroniser,
//             mid-bit sampling, false-start rejection, break handling and a
//             small FIFO of {data, frame_err, parity_err} behind valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 m_ready,
  output logic                 m_valid,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_frame_err,
  output logic                 m_parity_err,
  output logic                 overrun,
  output logic                 busy
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int c_BIT_PERIOD = CLK_FREQ / BAUD_RATE;
  localparam int c_HALF       = c_BIT_PERIOD / 2;
  localparam int c_CNT_W      = $clog2(c_BIT_PERIOD);
  localparam int c_IDX_W      = $clog2(DATA_BITS);
  localparam int c_PTR_W      = $clog2(FIFO_DEPTH);
  localparam int c_OCC_W      = c_PTR_W + 1;

  localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(c_BIT_PERIOD - 1);
  localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(c_HALF - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(DATA_BITS - 1);
  localparam logic               c_STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [c_OCC_W-1:0] c_OCC_FULL  = c_OCC_W'(FIFO_DEPTH);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_START  = 3'd1;
  localparam logic [2:0] c_ST_DATA   = 3'd2;
  localparam logic [2:0] c_ST_PARITY = 3'd3;
  localparam logic [2:0] c_ST_STOP   = 3'd4;
  localparam logic [2:0] c_ST_BREAK  = 3'd5;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic                 r_rx_meta;
  logic                 r_rx_s;

  logic [2:0]           r_state;
  logic [2:0]           w_state_next;

  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_IDX_W-1:0]   r_bit_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_frame_err;
  logic                 r_parity_err;

  logic                 w_bit_tick;
  logic                 w_half_tick;
  logic                 w_sample;
  logic                 w_push;
  logic                 w_push_fe;
  logic                 w_par_err;

  logic [DATA_BITS-1:0] r_mem_data [0:FIFO_DEPTH-1];
  logic                 r_mem_fe   [0:FIFO_DEPTH-1];
  logic                 r_mem_pe   [0:FIFO_DEPTH-1];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_OCC_W-1:0]   r_occ;
  logic                 r_overrun;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_wr_en;

  // --------------------------------------------------------------------------
  // Receiver
  // --------------------------------------------------------------------------

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_bit_tick  = (r_cnt == c_BIT_LAST);
  assign w_half_tick = (r_cnt == c_HALF_LAST);

  // Parity check on the sampled parity bit against the assembled data word.
  if (PARITY == 0) begin : g_par_none
    assign w_par_err = 1'b0;
  end else if (PARITY == 1) begin : g_par_odd
    assign w_par_err = ~(^{r_data, r_rx_s});
  end else begin : g_par_even
    assign w_par_err = ^{r_data, r_rx_s};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (!r_rx_s) w_state_next = c_ST_START;
      end
      c_ST_START: begin
        if (w_half_tick) w_state_next = r_rx_s ? c_ST_IDLE : c_ST_DATA;
      end
      c_ST_DATA: begin
        if (w_bit_tick && (r_bit_idx == c_IDX_LAST)) begin
          w_state_next = (PARITY != 0) ? c_ST_PARITY : c_ST_STOP;
        end
      end
      c_ST_PARITY: begin
        if (w_bit_tick) w_state_next = c_ST_STOP;
      end
      c_ST_STOP: begin
        // A low final stop bit means the line may be held in break.
        if (w_bit_tick && (r_stop_idx == c_STOP_LAST)) begin
          w_state_next = r_rx_s ? c_ST_IDLE : c_ST_BREAK;
        end
      end
      c_ST_BREAK: begin
        if (r_rx_s) w_state_next = c_ST_IDLE;
      end
      default: w_state_next = c_ST_IDLE;
    endcase
  end

  // FSM outputs: busy flag, mid-bit sample strobe and the frame push request.
  always_comb begin
    busy     = (r_state != c_ST_IDLE);
    w_sample = 1'b0;
    w_push   = 1'b0;
    case (r_state)
      c_ST_START:             w_sample = w_half_tick;
      c_ST_DATA, c_ST_PARITY: w_sample = w_bit_tick;
      c_ST_STOP: begin
        w_sample = w_bit_tick;
        w_push   = w_bit_tick && (r_stop_idx == c_STOP_LAST);
      end
      default: ;
    endcase
  end

  // The final stop sample is folded straight into the pushed frame error.
  assign w_push_fe = r_frame_err | ~r_rx_s;

  // Bit timer, bit indices and the assembled frame contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_stop_idx   <= 1'b0;
      r_data       <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_sample || (w_state_next != r_state) ||
          (r_state == c_ST_IDLE) || (r_state == c_ST_BREAK)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end

      case (r_state)
        c_ST_IDLE: begin
          if (w_state_next == c_ST_START) begin
            r_bit_idx    <= '0;
            r_stop_idx   <= 1'b0;
            r_data       <= '0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
          end
        end
        c_ST_DATA: begin
          if (w_sample) begin
            r_data[r_bit_idx] <= r_rx_s;
            r_bit_idx         <= r_bit_idx + c_IDX_W'(1);
          end
        end
        c_ST_PARITY: begin
          if (w_sample) r_parity_err <= w_par_err;
        end
        c_ST_STOP: begin
          if (w_sample) begin
            if (!r_rx_s) r_frame_err <= 1'b1;
            r_stop_idx <= r_stop_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO
  // --------------------------------------------------------------------------
  assign m_valid = (r_occ != '0);
  assign w_full  = (r_occ == c_OCC_FULL);
  assign w_pop   = m_valid && m_ready;
  // A full FIFO still takes the frame when the head leaves in the same cycle.
  assign w_wr_en = w_push && (!w_full || w_pop);

  // Entry storage; contents are only visible while the entry is valid.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_data[r_wr_ptr] <= r_data;
      r_mem_fe[r_wr_ptr]   <= w_push_fe;
      r_mem_pe[r_wr_ptr]   <= r_parity_err;
    end
  end

  // Pointers, occupancy and the dropped-frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_occ     <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_wr_en, w_pop})
        2'b10:   r_occ <= r_occ + c_OCC_W'(1);
        2'b01:   r_occ <= r_occ - c_OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
      r_overrun <= w_push && !w_wr_en;
    end
  end

  assign overrun      = r_overrun;
  assign m_data       = m_valid ? r_mem_data[r_rd_ptr] : '0;
  assign m_frame_err  = m_valid ? r_mem_fe[r_rd_ptr]   : 1'b0;
  assign m_parity_err = m_valid ? r_mem_pe[r_rd_ptr]   : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_fifo
//  Purpose  : Directed self-checking bench for uart_rx_fifo: an 8N1 instance
//             (a) and an 8E1 instance (b), both at BIT_PERIOD = 10.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic       m_ready_a = 1'b1;
  logic       m_ready_b = 1'b1;

  logic       m_valid_a, m_frame_err_a, m_parity_err_a, overrun_a, busy_a;
  logic [7:0] m_data_a;
  logic       m_valid_b, m_frame_err_b, m_parity_err_b, overrun_b, busy_b;
  logic [7:0] m_data_b;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         ovr_a = 0;
  logic       prev_va = 1'b0;
  logic [9:0] q_a[$];
  logic [9:0] q_b[$];
  int         rise_a[$];

  uart_rx_fifo #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .m_ready(m_ready_a),
    .m_valid(m_valid_a), .m_data(m_data_a), .m_frame_err(m_frame_err_a),
    .m_parity_err(m_parity_err_a), .overrun(overrun_a), .busy(busy_a)
  );

  uart_rx_fifo #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .m_ready(m_ready_b),
    .m_valid(m_valid_b), .m_data(m_data_b), .m_frame_err(m_frame_err_b),
    .m_parity_err(m_parity_err_b), .overrun(overrun_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every popped entry, every overrun pulse and every m_valid rise.
  always @(negedge clk) begin
    if (m_valid_a && m_ready_a) q_a.push_back({m_frame_err_a, m_parity_err_a, m_data_a});
    if (m_valid_b && m_ready_b) q_b.push_back({m_frame_err_b, m_parity_err_b, m_data_b});
    if (overrun_a) ovr_a <= ovr_a + 1;
    if (m_valid_a && !prev_va) rise_a.push_back(cyc);
    prev_va <= m_valid_a;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive n frame bits LSB first, 10 clocks per bit.
  task automatic send_a(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_a = bits[i];
      step(10);
    end
    rx_a = 1'b1;
  endtask

  task automatic send_b(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_b = bits[i];
      step(10);
    end
    rx_b = 1'b1;
  endtask

  task automatic test_reset;
    rx_a = 1'b0;
    step(6);
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy_a: got %b expected 0", busy_a); end
    n_checks++; if (m_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a: got %b expected 0", m_valid_a); end
    n_checks++; if (m_data_a !== 8'h00) begin n_fail++; $display("FAIL reset_data_a: got %h expected 00", m_data_a); end
    n_checks++; if ({m_frame_err_a, m_parity_err_a} !== 2'b00) begin n_fail++; $display("FAIL reset_errs_a: got %b expected 00", {m_frame_err_a, m_parity_err_a}); end
    n_checks++; if (overrun_a !== 1'b0) begin n_fail++; $display("FAIL reset_overrun_a: got %b expected 0", overrun_a); end
    n_checks++; if ({m_valid_b, busy_b, overrun_b} !== 3'b000) begin n_fail++; $display("FAIL reset_b: got %b expected 000", {m_valid_b, busy_b, overrun_b}); end
    rx_a = 1'b1;
    step(4);
  endtask

  task automatic test_basic;
    logic [7:0] pats [3];
    int base, rb, ob, t0;
    pats[0] = 8'hA5; pats[1] = 8'h00; pats[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      base = q_a.size(); rb = rise_a.size(); ob = ovr_a; t0 = cyc;
      send_a({6'b0, 1'b1, pats[i], 1'b0}, 10);
      step(10);
      n_checks++; if (q_a.size() !== base + 1) begin n_fail++; $display("FAIL basic_count: got %0d expected %0d", q_a.size(), base + 1); end
      else begin
        n_checks++; if (q_a[base] !== {2'b00, pats[i]}) begin n_fail++; $display("FAIL basic_entry: got %h expected %h", q_a[base], {2'b00, pats[i]}); end
      end
      n_checks++; if (ovr_a !== ob) begin n_fail++; $display("FAIL basic_overrun: got %0d expected %0d", ovr_a - ob, 0); end
      if (i == 0) begin
        n_checks++;
        if (rise_a.size() <= rb) begin n_fail++; $display("FAIL basic_latency: got no m_valid rise expected 98"); end
        else if (rise_a[rb] - t0 !== 98) begin n_fail++; $display("FAIL basic_latency: got %0d expected 98", rise_a[rb] - t0); end
      end
    end
  endtask

  task automatic test_parity;
    int base;
    // 0x07 has three ones: parity bit 0 makes the total odd, an even-mode error.
    base = q_b.size();
    send_b({5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    step(10);
    send_b({5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    step(10);
    n_checks++; if (q_b.size() !== base + 2) begin n_fail++; $display("FAIL parity_count: got %0d expected %0d", q_b.size(), base + 2); end
    else begin
      n_checks++; if (q_b[base] !== 10'b01_0000_0111) begin n_fail++; $display("FAIL parity_bad: got %h expected %h", q_b[base], 10'b01_0000_0111); end
      n_checks++; if (q_b[base+1] !== 10'b00_0000_0111) begin n_fail++; $display("FAIL parity_good: got %h expected %h", q_b[base+1], 10'b00_0000_0111); end
    end
  endtask

  task automatic test_break;
    int base, drops;
    base = q_a.size();
    send_a({6'b0, 1'b0, 8'h3C, 1'b0}, 10);
    rx_a = 1'b0;
    drops = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (busy_a !== 1'b1) drops++;
    end
    n_checks++; if (drops !== 0) begin n_fail++; $display("FAIL break_busy_hold: got %0d idle cycles expected 0", drops); end
    rx_a = 1'b1;
    step(5);
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL break_release: got %b expected 0", busy_a); end
    step(10);
    n_checks++; if (q_a.size() !== base + 1) begin n_fail++; $display("FAIL break_count: got %0d expected %0d", q_a.size(), base + 1); end
    else begin
      n_checks++; if (q_a[base] !== 10'b10_0011_1100) begin n_fail++; $display("FAIL break_entry: got %h expected %h", q_a[base], 10'b10_0011_1100); end
    end
    send_a({6'b0, 1'b1, 8'h55, 1'b0}, 10);
    step(10);
    n_checks++; if (q_a.size() !== base + 2) begin n_fail++; $display("FAIL break_next_count: got %0d expected %0d", q_a.size(), base + 2); end
    else begin
      n_checks++; if (q_a[base+1] !== 10'h055) begin n_fail++; $display("FAIL break_next_entry: got %h expected 055", q_a[base+1]); end
    end
  endtask

  task automatic test_glitch;
    int base;
    base = q_a.size();
    rx_a = 1'b0;
    step(3);
    rx_a = 1'b1;
    step(4);
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_before: got %b expected 1", busy_a); end
    step(1);
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_after: got %b expected 0", busy_a); end
    step(100);
    n_checks++; if (q_a.size() !== base) begin n_fail++; $display("FAIL glitch_count: got %0d expected %0d", q_a.size(), base); end
  endtask

  task automatic test_overrun;
    int base, ob;
    logic [7:0] d;
    base = q_a.size(); ob = ovr_a;
    m_ready_a = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      d = 8'(i);
      send_a({6'b0, 1'b1, d, 1'b0}, 10);
    end
    n_checks++; if (ovr_a !== ob) begin n_fail++; $display("FAIL overrun_early: got %0d expected 0", ovr_a - ob); end
    n_checks++; if (m_valid_a !== 1'b1) begin n_fail++; $display("FAIL overrun_valid_held: got %b expected 1", m_valid_a); end
    send_a({6'b0, 1'b1, 8'h05, 1'b0}, 10);
    step(10);
    n_checks++; if (ovr_a - ob !== 1) begin n_fail++; $display("FAIL overrun_pulses: got %0d expected 1", ovr_a - ob); end
    m_ready_a = 1'b1;
    step(10);
    n_checks++; if (q_a.size() !== base + 4) begin n_fail++; $display("FAIL overrun_pops: got %0d expected %0d", q_a.size() - base, 4); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (q_a[base+i] !== 10'(i + 1)) begin n_fail++; $display("FAIL overrun_order: got %h expected %h", q_a[base+i], 10'(i + 1)); end
      end
    end
    n_checks++; if (m_valid_a !== 1'b0) begin n_fail++; $display("FAIL overrun_drained: got %b expected 0", m_valid_a); end
  endtask

  task automatic test_reset_mid;
    int base;
    logic [7:0] d;
    base = q_a.size();
    d = 8'hF0;
    rx_a = 1'b0;
    step(10);
    for (int i = 0; i < 4; i++) begin
      rx_a = d[i];
      step(10);
    end
    rx_a = d[4];
    step(2);
    rst = 1'b1;
    step(1);
    n_checks++; if ({busy_a, m_valid_a, overrun_a, m_frame_err_a, m_parity_err_a} !== 5'b0) begin
      n_fail++; $display("FAIL midreset_outputs: got %b expected 00000", {busy_a, m_valid_a, overrun_a, m_frame_err_a, m_parity_err_a});
    end
    n_checks++; if (m_data_a !== 8'h00) begin n_fail++; $display("FAIL midreset_data: got %h expected 00", m_data_a); end
    rst = 1'b0;
    for (int i = 5; i < 8; i++) begin
      rx_a = d[i];
      step(10);
    end
    rx_a = 1'b1;
    step(30);
    n_checks++; if (q_a.size() !== base) begin n_fail++; $display("FAIL midreset_no_entry: got %0d expected %0d", q_a.size(), base); end
    send_a({6'b0, 1'b1, 8'h81, 1'b0}, 10);
    step(10);
    n_checks++; if (q_a.size() !== base + 1) begin n_fail++; $display("FAIL midreset_next_count: got %0d expected %0d", q_a.size(), base + 1); end
    else begin
      n_checks++; if (q_a[base] !== 10'h081) begin n_fail++; $display("FAIL midreset_next_entry: got %h expected 081", q_a[base]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    step(3);
    test_reset;
    rst = 1'b0;
    step(5);
    test_basic;
    test_parity;
    test_break;
    test_glitch;
    test_overrun;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
